// File: rtl/vp_key_scheduler_if.sv
// Keymap-side event handshake of vp_key_scheduler.
// The scheduler presents one event at a time, and the keymap answers with a read pulse.
interface vp_key_scheduler_if;
    logic       rx_data_ready_o;
    logic [7:0] rx_ascii_o;
    logic       rx_released_o;
    logic       rx_read_i;

    modport master (
        output rx_data_ready_o,
        output rx_ascii_o,
        output rx_released_o,
        input  rx_read_i
    );

    modport slave (
        input  rx_data_ready_o,
        input  rx_ascii_o,
        input  rx_released_o,
        output rx_read_i
    );
endinterface

// File: rtl/vp_key_scheduler.sv
// Merges PS/2 key events and gamepad numpad buttons into one ordered
// event stream (FIFO + present/ack/gap FSM) for the keymap rx port.
module vp_key_scheduler #(
    parameter int FIFO_DEPTH  = 8,
    parameter int ACK_TIMEOUT = 4096,
    parameter int GAP_CYCLES  = 2
) (
    input  logic                        clk_i,
    input  logic                        res_n_i,
    input  logic [10:0]                 ps2_key_i,
    input  logic [9:0]                  joy_numpad_i,
    vp_key_scheduler_if.master          rx,
    output logic                        overflow_o,
    output logic                        timeout_o,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(ACK_TIMEOUT + 1);

    localparam logic [LW-1:0] FULL_LVL = LW'(FIFO_DEPTH);
    localparam logic [CW-1:0] TO_LAST  = CW'(ACK_TIMEOUT - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRESENT,
        S_GAP
    } state_t;

    // The extended flag does not change the key code.
    logic unused_ext;
    assign unused_ext = ps2_key_i[8];

    // PS/2 set-2 scancode to key code; bit 8 flags a mapped code.
    function automatic logic [8:0] ps2_map(input logic [7:0] sc);
        logic [8:0] r;
        r = 9'h000;
        unique case (sc)
            8'h16: r = {1'b1, 8'h31};
            8'h1E: r = {1'b1, 8'h32};
            8'h26: r = {1'b1, 8'h33};
            8'h25: r = {1'b1, 8'h34};
            8'h2E: r = {1'b1, 8'h35};
            8'h36: r = {1'b1, 8'h36};
            8'h3D: r = {1'b1, 8'h37};
            8'h3E: r = {1'b1, 8'h38};
            8'h46: r = {1'b1, 8'h39};
            8'h45: r = {1'b1, 8'h30};
            8'h1C: r = {1'b1, 8'h61};
            8'h32: r = {1'b1, 8'h62};
            8'h21: r = {1'b1, 8'h63};
            8'h23: r = {1'b1, 8'h64};
            8'h24: r = {1'b1, 8'h65};
            8'h2B: r = {1'b1, 8'h66};
            8'h34: r = {1'b1, 8'h67};
            8'h33: r = {1'b1, 8'h68};
            8'h43: r = {1'b1, 8'h69};
            8'h3B: r = {1'b1, 8'h6A};
            8'h42: r = {1'b1, 8'h6B};
            8'h4B: r = {1'b1, 8'h6C};
            8'h3A: r = {1'b1, 8'h6D};
            8'h31: r = {1'b1, 8'h6E};
            8'h44: r = {1'b1, 8'h6F};
            8'h4D: r = {1'b1, 8'h70};
            8'h15: r = {1'b1, 8'h71};
            8'h2D: r = {1'b1, 8'h72};
            8'h1B: r = {1'b1, 8'h73};
            8'h2C: r = {1'b1, 8'h74};
            8'h3C: r = {1'b1, 8'h75};
            8'h2A: r = {1'b1, 8'h76};
            8'h1D: r = {1'b1, 8'h77};
            8'h22: r = {1'b1, 8'h78};
            8'h35: r = {1'b1, 8'h79};
            8'h1A: r = {1'b1, 8'h7A};
            8'h29: r = {1'b1, 8'h20};
            8'h79: r = {1'b1, 8'h2B};
            8'h7B: r = {1'b1, 8'h2D};
            8'h7C: r = {1'b1, 8'h2A};
            8'h4A: r = {1'b1, 8'h2F};
            8'h55: r = {1'b1, 8'h3D};
            8'h1F: r = {1'b1, 8'h11};
            8'h27: r = {1'b1, 8'h12};
            8'h5A: r = {1'b1, 8'h0A};
            8'h66: r = {1'b1, 8'h08};
            default: r = 9'h000;
        endcase
        return r;
    endfunction

    logic [1:0] rst_sync_q;
    logic       rst_n;

    logic       primed_q;
    logic       toggle_q;
    logic       ps2_vld_q;
    logic [8:0] ps2_evt_q;
    logic [8:0] ps2_dec;

    logic [9:0] joy_q;
    logic [9:0] sent_q;
    logic [9:0] diff;
    logic       joy_hit;
    logic [3:0] joy_idx;
    logic [7:0] joy_ascii;
    logic [8:0] joy_word;

    logic [8:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [LW-1:0] level_q;
    logic          full;
    logic          empty;
    logic          ps2_push;
    logic          joy_push;
    logic          push;
    logic          pop;
    logic [8:0]    push_data;

    state_t        state_q;
    state_t        state_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          ready_q;
    logic          ready_d;
    logic          timeout_q;
    logic          timeout_d;
    logic [7:0]    ascii_q;
    logic          rel_q;
    logic          ovf_q;

    // Assert reset at once, release it on a clock edge.
    always_ff @(posedge clk_i or negedge res_n_i) begin
        if (!res_n_i) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_n = rst_sync_q[1];

    assign ps2_dec = ps2_map(ps2_key_i[7:0]);

    // Detect strobe toggles and latch the decoded event for next-cycle push.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            primed_q  <= 1'b0;
            toggle_q  <= 1'b0;
            ps2_vld_q <= 1'b0;
            ps2_evt_q <= 9'h000;
        end else begin
            primed_q  <= 1'b1;
            toggle_q  <= ps2_key_i[10];
            ps2_vld_q <= primed_q
                       && (ps2_key_i[10] != toggle_q)
                       && ps2_dec[8];
            ps2_evt_q <= {~ps2_key_i[9], ps2_dec[7:0]};
        end
    end

    assign diff = joy_q ^ sent_q;

    // Pick the lowest-numbered button whose level differs from what was sent.
    always_comb begin
        joy_hit = 1'b0;
        joy_idx = 4'd0;
        for (int i = 9; i >= 0; i--) begin
            if (diff[i]) begin
                joy_hit = 1'b1;
                joy_idx = 4'(i);
            end
        end
    end

    assign joy_ascii = (joy_idx == 4'd9) ? 8'h30
                                         : 8'h31 + {4'h0, joy_idx};
    assign joy_word  = {~joy_q[joy_idx], joy_ascii};

    assign full      = (level_q == FULL_LVL);
    assign empty     = (level_q == '0);
    assign ps2_push  = ps2_vld_q && !full;
    assign joy_push  = !ps2_vld_q && joy_hit && !full;
    assign push      = ps2_push || joy_push;
    assign push_data = ps2_vld_q ? ps2_evt_q : joy_word;

    // Track pad levels and what the keymap has been told.
    // A dropped PS/2 event sets the sticky overflow flag.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            joy_q  <= 10'h000;
            sent_q <= 10'h000;
            ovf_q  <= 1'b0;
        end else begin
            joy_q <= joy_numpad_i;
            if (joy_push) begin
                sent_q[joy_idx] <= joy_q[joy_idx];
            end
            if (ps2_vld_q && full) begin
                ovf_q <= 1'b1;
            end
        end
    end

    // Event storage; contents are don't-care until written.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    // FIFO pointers and occupancy; a pop never frees space for the same edge.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

    // Next-state logic for present / acknowledge / gap sequencing.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ready_d   = ready_q;
        timeout_d = 1'b0;
        pop       = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    ready_d = 1'b1;
                    cnt_d   = '0;
                    state_d = S_PRESENT;
                end
            end
            S_PRESENT: begin
                if (rx.rx_read_i) begin
                    ready_d = 1'b0;
                    cnt_d   = '0;
                    state_d = S_GAP;
                end else if (cnt_q == TO_LAST) begin
                    ready_d   = 1'b0;
                    timeout_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = S_GAP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                ready_d = 1'b0;
            end
        endcase
    end

    // FSM state and the presented event registers.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            ready_q   <= 1'b0;
            timeout_q <= 1'b0;
            ascii_q   <= 8'h00;
            rel_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ready_q   <= ready_d;
            timeout_q <= timeout_d;
            if (pop) begin
                ascii_q <= mem_q[rd_ptr_q][7:0];
                rel_q   <= mem_q[rd_ptr_q][8];
            end
        end
    end

    assign rx.rx_data_ready_o = ready_q;
    assign rx.rx_ascii_o      = ascii_q;
    assign rx.rx_released_o   = rel_q;
    assign overflow_o         = ovf_q;
    assign timeout_o          = timeout_q;
    assign fifo_level_o       = level_q;

endmodule

// File: tb/tb_vp_key_scheduler.sv
// Directed bench for vp_key_scheduler: PS/2 and pad merging, overflow,
// ack timeout, gap timing and reset behaviour.
module tb_vp_key_scheduler;

    logic        clk = 1'b0;
    logic        res_n = 1'b0;
    logic [10:0] ps2_key = 11'h000;
    logic [9:0]  joy = 10'h000;
    logic        ovf;
    logic        tmo;
    logic [3:0]  lvl;
    logic        tog = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    vp_key_scheduler_if rx_if ();

    vp_key_scheduler dut (
        .clk_i        (clk),
        .res_n_i      (res_n),
        .ps2_key_i    (ps2_key),
        .joy_numpad_i (joy),
        .rx           (rx_if),
        .overflow_o   (ovf),
        .timeout_o    (tmo),
        .fifo_level_o (lvl)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic ps2(input logic [7:0] sc, input logic make);
        tog = ~tog;
        ps2_key = {tog, make, 1'b0, sc};
    endtask

    task automatic expect_evt(input string tag, input logic [7:0] a,
                              input logic r);
        int w;
        w = 0;
        while (!rx_if.rx_data_ready_o && w < 64) begin
            tick(1);
            w++;
        end
        check({tag, " ready"}, rx_if.rx_data_ready_o, 1);
        check({tag, " ascii"}, rx_if.rx_ascii_o, a);
        check({tag, " rel"}, rx_if.rx_released_o, r);
        rx_if.rx_read_i = 1'b1;
        tick(1);
        rx_if.rx_read_i = 1'b0;
        check({tag, " ack"}, rx_if.rx_data_ready_o, 0);
    endtask

    initial begin
        logic [7:0] sc [10];
        logic [7:0] as [10];
        sc = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24,
               8'h2B, 8'h34, 8'h33, 8'h43, 8'h3B};
        as = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65,
               8'h66, 8'h67, 8'h68, 8'h69, 8'h6A};
        rx_if.rx_read_i = 1'b0;

        tick(3);
        check("rst ready", rx_if.rx_data_ready_o, 0);
        check("rst ascii", rx_if.rx_ascii_o, 0);
        check("rst level", lvl, 0);
        check("rst ovf", ovf, 0);
        check("rst tmo", tmo, 0);
        res_n = 1'b1;
        tick(6);

        ps2(8'h1C, 1'b1);
        tick(1);
        check("t1 k ready", rx_if.rx_data_ready_o, 0);
        tick(1);
        check("t1 k1 level", lvl, 1);
        check("t1 k1 ready", rx_if.rx_data_ready_o, 0);
        tick(1);
        check("t1 k2 ready", rx_if.rx_data_ready_o, 1);
        check("t1 ascii", rx_if.rx_ascii_o, 8'h61);
        check("t1 rel", rx_if.rx_released_o, 0);
        check("t1 level", lvl, 0);
        tick(20);
        check("t1 hold ready", rx_if.rx_data_ready_o, 1);
        check("t1 hold ascii", rx_if.rx_ascii_o, 8'h61);
        rx_if.rx_read_i = 1'b1;
        tick(1);
        rx_if.rx_read_i = 1'b0;
        check("t1 ack", rx_if.rx_data_ready_o, 0);
        tick(5);

        joy = 10'b0000000101;
        expect_evt("t2 p1", 8'h31, 1'b0);
        expect_evt("t2 p3", 8'h33, 1'b0);
        joy = 10'h000;
        expect_evt("t2 r1", 8'h31, 1'b1);
        expect_evt("t2 r3", 8'h33, 1'b1);
        tick(10);
        check("t2 idle", rx_if.rx_data_ready_o, 0);
        check("t2 level", lvl, 0);

        ps2(8'h1C, 1'b1);
        tick(1);
        ps2(8'h32, 1'b1);
        tick(2);
        check("t5 ready", rx_if.rx_data_ready_o, 1);
        check("t5 ascii", rx_if.rx_ascii_o, 8'h61);
        tick(4095);
        check("t5 pre ready", rx_if.rx_data_ready_o, 1);
        check("t5 pre tmo", tmo, 0);
        tick(1);
        check("t5 tmo ready", rx_if.rx_data_ready_o, 0);
        check("t5 tmo", tmo, 1);
        tick(1);
        check("t5 tmo pulse", tmo, 0);
        tick(1);
        check("t5 gap ready", rx_if.rx_data_ready_o, 0);
        tick(1);
        check("t5 next ready", rx_if.rx_data_ready_o, 1);
        check("t5 next ascii", rx_if.rx_ascii_o, 8'h62);
        rx_if.rx_read_i = 1'b1;
        tick(1);
        rx_if.rx_read_i = 1'b0;
        tick(10);

        for (int i = 0; i < 9; i++) begin
            ps2(sc[i], 1'b1);
            tick(1);
        end
        check("t4 level7", lvl, 7);
        tick(1);
        check("t4 level8", lvl, 8);
        check("t4 ovf0", ovf, 0);
        ps2(sc[9], 1'b1);
        tick(2);
        check("t4 ovf1", ovf, 1);
        check("t4 full", lvl, 8);

        joy = 10'h010;
        tick(3);
        joy = 10'h000;
        tick(3);
        check("t3 level", lvl, 8);
        check("t3 shown", rx_if.rx_ascii_o, 8'h61);
        for (int i = 0; i < 9; i++) begin
            expect_evt($sformatf("t3 drain%0d", i), as[i], 1'b0);
        end
        tick(20);
        check("t3 no5 ready", rx_if.rx_data_ready_o, 0);
        check("t3 no5 level", lvl, 0);
        check("t4 ovf sticky", ovf, 1);

        ps2(8'h1C, 1'b1);
        tick(1);
        ps2(8'h32, 1'b1);
        tick(2);
        check("t6 present", rx_if.rx_data_ready_o, 1);
        check("t6 tog", ps2_key[10], 1);
        res_n = 1'b0;
        #1;
        check("t6 rst ready", rx_if.rx_data_ready_o, 0);
        check("t6 rst ascii", rx_if.rx_ascii_o, 0);
        check("t6 rst level", lvl, 0);
        check("t6 rst ovf", ovf, 0);
        tick(2);
        res_n = 1'b1;
        tick(8);
        check("t6 noevt ready", rx_if.rx_data_ready_o, 0);
        check("t6 noevt level", lvl, 0);
        ps2(8'h76, 1'b1);
        tick(6);
        check("t6 76 ready", rx_if.rx_data_ready_o, 0);
        check("t6 76 level", lvl, 0);
        ps2(8'h29, 1'b1);
        expect_evt("t6 space", 8'h20, 1'b0);
        ps2(8'h5A, 1'b0);
        expect_evt("t6 enter rel", 8'h0A, 1'b1);

        joy = 10'h200;
        tick(2);
        res_n = 1'b0;
        tick(2);
        res_n = 1'b1;
        expect_evt("held p0", 8'h30, 1'b0);
        joy = 10'h000;
        expect_evt("held r0", 8'h30, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
